// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, register file and bit-timing FSM.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_mmio #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // IDLE wait for data | START low bit | DATA 8 bits LSB first | PARITY | STOP high bit
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_pop;
    logic          w_tick;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_push_ok;
    logic [7:0]    w_head;
    logic [7:0]    w_count8;

    logic [15:0]   r_div;
    logic [3:0]    r_ctrl;
    logic          r_ovf;
    logic [31:0]   r_rdata;
    logic          r_irq;
    logic          w_wr;
    logic          w_rd;
    logic [15:0]   w_div_eff;
    logic          w_busy;

    logic          r_tx;
    logic [7:0]    r_shift;
    logic [2:0]    r_idx;
    logic [15:0]   r_cnt;
    logic [15:0]   r_period;
    logic          r_par;
    logic          r_par_en;

    logic          w_unused;
    assign w_unused = ^{data_i[31:16], addr_i[1:0]};

    assign w_wr       = en_i && (we_i != 4'b0000);
    assign w_rd       = en_i && (we_i == 4'b0000);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_push_req = en_i && we_i[0] && (addr_i[3:2] == 2'd0);
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_head     = r_mem[r_rptr];
    assign w_count8   = 8'(r_count);
    assign w_busy     = (r_state != S_IDLE);
    assign w_div_eff  = (r_div < 16'd2) ? 16'd2 : r_div;
    assign w_tick     = (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= data_i[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= DEFAULT_DIV;
            r_ctrl  <= 4'h0;
            r_ovf   <= 1'b0;
            r_rdata <= 32'h0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && addr_i[3:2] == 2'd2) begin
                if (we_i[0]) r_div[7:0]  <= data_i[7:0];
                if (we_i[1]) r_div[15:8] <= data_i[15:8];
            end
            if (w_wr && addr_i[3:2] == 2'd3 && we_i[0]) begin
`ifdef UART_TX_PARITY_EN
                r_ctrl <= data_i[3:0];
`else
                r_ctrl <= {2'b00, data_i[1:0]};
`endif
            end
            if (w_push_req && !w_push_ok)
                r_ovf <= 1'b1;
            else if (w_wr && addr_i[3:2] == 2'd1 && we_i[0] && data_i[3])
                r_ovf <= 1'b0;
            if (w_rd) begin
                case (addr_i[3:2])
                    2'd0:    r_rdata <= 32'h0;
                    2'd1:    r_rdata <= {16'h0, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
                    2'd2:    r_rdata <= {16'h0, r_div};
                    default: r_rdata <= {28'h0, r_ctrl};
                endcase
            end
            r_irq <= r_ctrl[1] && w_empty && !w_busy;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0] && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_ctrl[0] && !w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_shift  <= 8'h0;
            r_idx    <= 3'd0;
            r_cnt    <= 16'd0;
            r_period <= 16'd2;
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_shift  <= w_head;
                r_period <= w_div_eff;
                r_cnt    <= w_div_eff - 16'd1;
                r_idx    <= 3'd0;
                r_tx     <= 1'b0;
                r_par    <= (^w_head) ^ r_ctrl[3];
                r_par_en <= r_ctrl[2];
            end else if (r_state != S_IDLE) begin
                if (!w_tick) begin
                    r_cnt <= r_cnt - 16'd1;
                end else begin
                    r_cnt <= r_period - 16'd1;
                    case (r_state)
                        S_START: r_tx <= r_shift[0];
                        S_DATA: begin
                            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                r_tx <= r_par_en ? r_par : 1'b1;
`else
                                r_tx <= 1'b1;
`endif
                            end else begin
                                r_shift <= r_shift >> 1;
                                r_tx    <= r_shift[1];
                                r_idx   <= r_idx + 3'd1;
                            end
                        end
                        default: r_tx <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign data_o = r_rdata;
    assign tx_o   = r_tx;
    assign irq_o  = r_irq;

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core data bus, decoded in the peripheral region beside the RTC and PLIC.
- Replaces the simulation-only character output register with synthesizable serial output.
- The CPU writes bytes into a TX FIFO. A bit-timing engine serializes them as 8N1 frames on tx_o.
- Status, divisor, control and an empty-interrupt are readable and writable over the same bus.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of two, minimum 2.
- DEFAULT_DIV, 16'd868, reset value of the DIV register (clock cycles per bit; 100 MHz / 115200).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-high reset
- en_i  in  1  peripheral select, valid for one cycle per access
- we_i  in  4  byte write enables; '0 means read
- addr_i  in  4  byte offset; addr_i[3:2] selects the register
- data_i  in  32  write data
- data_o  out  32  read data, registered
- tx_o  out  1  serial output, idle high
- irq_o  out  1  level interrupt

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values:
  - tx_o=1, irq_o=0, data_o=0
  - FIFO empty, state IDLE
  - DIV=DEFAULT_DIV, CTRL=0, overflow flag=0
- Register map (word offsets):
  - 0x0 TXDATA:
    - Write with we_i[0]=1 pushes data_i[7:0].
    - Read returns 0.
  - 0x4 STATUS, read-only except bit3:
    - [0] full, [1] empty, [2] busy (state!=IDLE), [3] overflow (sticky), [15:8] FIFO count.
    - Writing 1 to bit3 clears overflow.
  - 0x8 DIV:
    - [15:0] cycles per bit; byte-enabled write.
    - A value of 0 or 1 is treated as 2.
  - 0xC CTRL: [0] tx_enable, [1] irq_enable.
- Reads: data_o updates on the clock edge after en_i && we_i==0, giving one-cycle latency. When not reading, data_o holds its previous value.
- FIFO push rules:
  - A push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- TX FSM, one-hot or encoded, states IDLE, START, DATA, STOP:
  - IDLE → START: when tx_enable && !empty. The head byte is popped into the shift register, DIV is latched into the bit-period register, and tx_o=0.
  - Bit timing: each bit lasts exactly the latched period. A down-counter reloads at every bit boundary.
  - START → DATA: after one period. Eight bits are sent LSB first; the bit index counts 0..7.
  - DATA → STOP: after bit 7; tx_o=1 for one period.
  - STOP → START: if tx_enable && !empty, back-to-back with no idle gap.
  - STOP → IDLE: otherwise.
- DIV writes during a frame take effect at the next frame start.
- Clearing tx_enable mid-frame finishes the current frame, then the FSM goes to IDLE.
- Reset mid-frame forces tx_o=1 immediately and discards FIFO contents.
- irq_o = irq_enable && empty && !busy, registered (one cycle after the condition becomes true).
- tx_o is driven from a flop, with no combinational path from the bus.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - CTRL[2] = parity_enable, CTRL[3] = odd parity.
  - When parity_enable=1, a PARITY state is inserted between DATA and STOP, one period long.
  - Even parity: XOR of the 8 data bits. Odd parity: its inverse.
  - STATUS and the remaining fields are unchanged.
- Undefined:
  - CTRL[3:2] read as 0 and ignore writes.
  - No PARITY state exists; frames are always 10 bits.

Test Plan:
- Single byte, DIV=4:
  - After reset set CTRL=1, then write 0x55 to TXDATA.
  - tx_o sequence, each level lasting 4 cycles: 0,1,0,1,0,1,0,1,0,1.
  - Then idle 1; the frame spans 40 cycles. busy=0 afterwards and STATUS=0x0000_0002.
- Overflow with FIFO_DEPTH=16, tx_enable=0:
  - Push 17 bytes.
  - STATUS reads count=16, full=1, overflow=1.
  - Writing 0x8 to STATUS clears overflow only; count stays 16.
- Back-to-back frames:
  - Enable with 3 bytes queued (0x00,0xFF,0xA5) and DIV=2.
  - Stop bit of each frame is followed immediately by the next start bit.
  - Total 60 cycles from first start to last stop end.
- DIV change mid-frame:
  - Set DIV=8 during frame 1, which was started with DIV=4.
  - Frame 1 stays at 4 cycles per bit; frame 2 uses 8 cycles per bit.
- Interrupt and reset:
  - CTRL=3 with one byte queued: irq_o=0 during the frame, and irq_o=1 one cycle after the return to IDLE.
  - Asserting reset mid-DATA forces tx_o=1 and irq_o=0 asynchronously, and STATUS reads 0x0000_0002 after release.
- Parity (UART_TX_PARITY_EN defined):
  - CTRL=0x5 (enable + even parity) and send 0x07: tx_o emits an 11-bit frame with parity bit 1.
  - With CTRL=0xD (odd parity) the parity bit is 0.
